// File: rtl/time_entry_loader.sv
// ---------------------------------------------------------------------------
// time_entry_loader
//
// Keypad-to-timer front end of the microwave oven. BCD keypresses are
// shifted into a 4-digit MM:SS buffer. The entry is validated on START.
// The block then drives the load/stop/clear controls and the parallel BCD
// digits of the downstream mod-10/mod-6 down-counter chain. It also tracks
// the cook state (idle/entry/load/run/pause).
//
// Ports
//   clk          in   system clock, all state on posedge
//   rst_n        in   asynchronous active-low reset
//   key_valid    in   key strobe level; one action per rising edge
//   key_code     in   0-9 digit, 4'hA CLEAR, 4'hB START, 4'hC-4'hF ignored
//   door_closed  in   1 = door shut; cooking only while 1
//   timer_done   in   AND of all counter zero flags (used in RUN only)
//   min_tens     out  BCD digit to the minutes-tens counter
//   min_units    out  BCD digit to the minutes-units counter
//   sec_tens     out  BCD digit to the seconds-tens (mod-6) counter
//   sec_units    out  BCD digit to the seconds-units counter
//   load         out  one-cycle pulse; counters capture the digits
//   stop         out  1 = counters hold
//   clear_cnt    out  one-cycle pulse; counters forced to 0
//   running      out  1 while in RUN
//   err          out  one-cycle pulse on a rejected START
// ---------------------------------------------------------------------------
module time_entry_loader #(
  parameter int MAX_SEC_TENS = 5,
  parameter int MAX_DIGITS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       load,
  output logic       stop,
  output logic       clear_cnt,
  output logic       running,
  output logic       err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        buf_q, buf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               key_valid_q, key_valid_d;
  logic               err_q, err_d;
  logic               clear_cnt_q, clear_cnt_d;

  logic               key_event;
  logic               is_digit;
  logic               has_room;
  logic               entry_ok;

  // A held key produces a single event on its rising edge.
  assign key_event = key_valid & ~key_valid_q;
  assign is_digit  = (key_code <= 4'd9);
  assign has_room  = (count_q < CNT_W'(MAX_DIGITS));
  // Seconds-tens must fit the mod-6 counter. An all-zero time would finish
  // immediately, so it is rejected. The door must be shut to cook.
  assign entry_ok  = (buf_q[7:4] <= 4'(MAX_SEC_TENS)) && (buf_q != 16'h0000) &&
                     door_closed;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    key_valid_d = key_valid;
    err_d       = 1'b0;
    clear_cnt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_event && is_digit) begin
          buf_d   = {buf_q[11:0], key_code};
          count_d = count_q + 1'b1;
          state_d = ENTRY;
        end
      end

      ENTRY: begin
        if (key_event) begin
          if (is_digit) begin
            if (has_room) begin
              buf_d   = {buf_q[11:0], key_code};
              count_d = count_q + 1'b1;
            end
          end else if (key_code == KEY_CLEAR) begin
            buf_d   = 16'h0000;
            count_d = '0;
            state_d = IDLE;
          end else if (key_code == KEY_START) begin
            if (entry_ok) state_d = LOAD;
            else          err_d   = 1'b1;
          end
        end
      end

      LOAD: state_d = RUN;

      RUN: begin
        // Order of checks: timer_done first, then door open, then CLEAR.
        if (timer_done) begin
          buf_d   = 16'h0000;
          count_d = '0;
          state_d = IDLE;
        end else if (!door_closed) begin
          state_d = PAUSE;
        end else if (key_event && key_code == KEY_CLEAR) begin
          buf_d       = 16'h0000;
          count_d     = '0;
          clear_cnt_d = 1'b1;
          state_d     = IDLE;
        end
      end

      PAUSE: begin
        if (key_event) begin
          if (key_code == KEY_START && door_closed) begin
            // Resume without reload; the counters kept the remaining time.
            state_d = RUN;
          end else if (key_code == KEY_CLEAR) begin
            buf_d       = 16'h0000;
            count_d     = '0;
            clear_cnt_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= 16'h0000;
      count_q     <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      clear_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  assign min_tens  = buf_q[15:12];
  assign min_units = buf_q[11:8];
  assign sec_tens  = buf_q[7:4];
  assign sec_units = buf_q[3:0];

  // The counters honour load only while stop is low, so LOAD also releases stop.
  assign load      = (state_q == LOAD);
  assign stop      = !((state_q == LOAD) || (state_q == RUN));
  assign running   = (state_q == RUN);
  assign err       = err_q;
  assign clear_cnt = clear_cnt_q;

endmodule
